// File: rtl/mxalu11u_issuer.sv
// Sequential front end for the MX 1-byte unsigned ALU: registers a request,
// holds the ALU selected for SETTLE cycles, captures and returns the result.
module mxalu11u_issuer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_opcode,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_f,
   output logic       rsp_x,
   output logic       rsp_y,
   output logic [4:0] rsp_flags,
   output logic [3:0] alu_opcode,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_cs_n,
   input  logic [7:0] alu_f,
   input  logic       alu_x,
   input  logic       alu_y,
   input  logic [4:0] alu_flags,
   output logic       busy,
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] cnt;
   logic       accept;

   // A waiting request may ride the response handshake straight into EXEC
   assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_f      <= '0;
         rsp_x      <= 1'b0;
         rsp_y      <= 1'b0;
         rsp_flags  <= '0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_cs_n   <= 1'b1;
         busy       <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  alu_opcode <= req_opcode;
                  alu_a      <= req_a;
                  alu_b      <= req_b;
                  cnt        <= CNT_INIT;
                  alu_cs_n   <= 1'b0;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == 4'd0) begin
                  rsp_f     <= alu_f;
                  rsp_x     <= alu_x;
                  rsp_y     <= alu_y;
                  rsp_flags <= alu_flags;
                  rsp_valid <= 1'b1;
                  alu_cs_n  <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  op_count  <= op_count + 8'd1;
                  rsp_valid <= 1'b0;
                  if (accept) begin
                     alu_opcode <= req_opcode;
                     alu_a      <= req_a;
                     alu_b      <= req_b;
                     cnt        <= CNT_INIT;
                     alu_cs_n   <= 1'b0;
                     state      <= EXEC;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               alu_cs_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/mxalu11u_issuer.md
# mxalu11u_issuer

Sequential front end for the MX 1-byte unsigned ALU. It accepts operation requests (opcode, A, B) over a valid/ready handshake and registers the operands. It then drives the ALU's combinational interface (opcode, a, b, cs_n) for a programmable settle window, captures result, x/y and flags, and returns them over a second valid/ready handshake. It sits between the instruction sequencer and the combinational ALU; it is the ALU's only driver.

## Interface
Parameters:
- SETTLE, default 1: number of cycles `alu_cs_n` is held low before capture. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request this cycle.
- req_opcode  in  4  ALU opcode.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_f  out  8  captured ALU result.
- rsp_x  out  1  captured carry-lookahead propagate (x).
- rsp_y  out  1  captured carry-lookahead generate (y).
- rsp_flags  out  5  captured ALU flags.
- alu_opcode  out  4  to ALU opcode.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_cs_n  out  1  to ALU cs_n; low only while executing.
- alu_f  in  8  from ALU f.
- alu_x  in  1  from ALU x.
- alu_y  in  1  from ALU y.
- alu_flags  in  5  from ALU flags.
- busy  out  1  high in any state other than IDLE.
- op_count  out  8  completed response handshakes, modulo 256.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch opcode/A/B into the operand registers.
  - Load the settle counter with SETTLE-1 and go to EXEC.
- EXEC:
  - `alu_cs_n`=0; `alu_opcode/a/b` driven from the operand registers.
  - Counter decrements each cycle.
  - When the counter is 0, capture `alu_f/x/y/flags` into the rsp_* registers and go to RESP.
  - `req_ready`=0.
- RESP:
  - `rsp_valid`=1; rsp_* held stable; `alu_cs_n`=1.
  - On `rsp_ready`, `op_count` increments (255 wraps to 0).
  - If `req_valid` is also high in that cycle, accept the new request (`req_ready` = `rsp_ready`, combinational) and go directly to EXEC. Otherwise go to IDLE.
- `rsp_valid` must never drop without `rsp_ready`. rsp_* never change while `rsp_valid`=1.
- `alu_opcode/a/b` hold their last values when `alu_cs_n`=1. They change only on request acceptance.
- `req_valid` while busy (EXEC, or RESP without `rsp_ready`) is stalled, not dropped. The requester must hold it.
- Reset mid-operation abandons the operation, and no response is produced.

## Timing
- Reset values: FSM=IDLE, `req_ready`=1, `rsp_valid`=0, `alu_cs_n`=1, `busy`=0, `op_count`=0. All rsp_* and alu_opcode/a/b are 0.
- Acceptance at edge E0 sets `alu_cs_n`=0 from E0 until E(SETTLE). Capture happens at E(SETTLE). `rsp_valid`=1 from E(SETTLE).
- Latency from acceptance to `rsp_valid` is SETTLE cycles. Back-to-back throughput is one operation per SETTLE+1 cycles, using the RESP→EXEC path.
- `rsp_valid` rises in the same edge that `alu_cs_n` rises.
- `req_ready` is the only combinational output: IDLE, or RESP with `rsp_ready` high.

## Test plan
Stub ALU for the bench: f=(a+b) mod 256, x=a[0], y=b[0], flags={1'b0, opcode}; outputs 0 when cs_n=1.
- Reset, then idle 5 cycles → `req_ready`=1, `alu_cs_n`=1, `rsp_valid`=0, `op_count`=0, `busy`=0.
- SETTLE=1, request op=4'h3, A=8'h12, B=8'h34, `rsp_ready`=1 → `alu_cs_n` low exactly 1 cycle; next cycle `rsp_valid`=1, rsp_f=8'h46, rsp_x=0, rsp_y=0, rsp_flags=5'h03; `op_count`=1.
- SETTLE=3, A=8'hFF, B=8'h02, `rsp_ready`=0 for 4 cycles → `alu_cs_n` low 3 cycles; rsp_f=8'h01 held stable with `rsp_valid`=1 throughout the stall; `req_ready`=0 while stalled.
- SETTLE=1, `req_valid` held high with 4 requests and `rsp_ready`=1 → one acceptance every 2 cycles via RESP→EXEC, never passing through IDLE; responses in order; `op_count`=4.
- Assert `rst_n` low during EXEC → `alu_cs_n`=1 and `rsp_valid`=0 immediately; after release no stale response; `op_count`=0.
- 256 completed operations → `op_count` wraps to 0; the 257th completion reads 1.
